// File: rtl/disp_scan_ctrl_if.sv
// Host-side write/commit port of the display scan controller.
//   wr_valid/wr_ready : shadow-buffer write handshake (transfer on valid & ready)
//   wr_addr           : digit index to write
//   wr_data           : segment pattern for that digit, active-high
//   wr_blink          : blink flag for that digit
//   commit            : pulse requesting a shadow -> active copy
//   commit_pending    : a commit has been requested but not yet applied
// master = host, slave = disp_scan_ctrl.
interface disp_scan_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int SEG_W  = 8
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [SEG_W-1:0]  wr_data;
  logic              wr_blink;
  logic              commit;
  logic              commit_pending;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_blink, commit,
    input  wr_ready, commit_pending
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_blink, commit,
    output wr_ready, commit_pending
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Multiplexed LED / 7-segment display scan controller.
// Steps a one-hot digit select through NUM_DIGITS digits, one scan tick at a
// time (rising edge of scan_clk), with BLANK_CYC all-off ticks before each
// digit and DWELL ticks of drive per digit. Digits flagged for blink are
// forced off while flash_clk is high. Host writes land in a shadow buffer and
// are copied to the displayed buffer only at a frame boundary (or at once
// when idle), so a frame never shows a mix of old and new data.
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-low
//   scan_clk   : scan tick source (level, rising edge = one tick)
//   flash_clk  : blink phase (level, high = blinking digits off)
//   enable     : 1 = scanning active
//   wr         : write/commit port (disp_scan_ctrl_if.slave)
//   dig_sel    : one-hot digit enable, active-high, registered
//   seg_out    : segment drive, active-high, registered
//   frame_done : 1-cycle pulse at the end of the last digit's dwell
//   busy       : controller is scanning (not idle)
module disp_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int ADDR_W     = 3,
  parameter int SEG_W      = 8,
  parameter int DWELL      = 16,
  parameter int BLANK_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_clk,
  input  logic                  flash_clk,
  input  logic                  enable,
  disp_scan_ctrl_if.slave       wr,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [SEG_W-1:0]      seg_out,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  // Input synchronizers
  logic s1, s2, flash_s, tick;

  // Scan state
  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // Registered-output next values
  logic [NUM_DIGITS-1:0] dig_sel_n;
  logic [SEG_W-1:0]      seg_n;
  logic                  frame_done_n;

  // Frame buffers and commit control
  logic [SEG_W-1:0] shadow_seg   [NUM_DIGITS];
  logic             shadow_blink [NUM_DIGITS];
  logic [SEG_W-1:0] active_seg   [NUM_DIGITS];
  logic             active_blink [NUM_DIGITS];
  logic             pending, pending_n, apply;
  logic [SEG_W-1:0] seg_src;
  logic             blink_src;
  logic             wr_accept;

  assign tick = s1 & ~s2;
  assign busy = (state != IDLE);

  assign wr.wr_ready       = ~pending;
  assign wr.commit_pending = pending;

  // Writes to addresses beyond the last digit complete the handshake but are
  // dropped.
  assign wr_accept = wr.wr_valid & ~pending & (int'(wr.wr_addr) < NUM_DIGITS);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    frame_done_n = 1'b0;

    if (!enable) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = (BLANK_CYC == 0) ? DRIVE : BLANK;
          idx_n   = '0;
          cnt_n   = '0;
        end
        BLANK: begin
          if (tick) begin
            if (cnt == CNT_W'(BLANK_CYC - 1)) begin
              state_n = DRIVE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        DRIVE: begin
          if (tick) begin
            if (cnt == CNT_W'(DWELL - 1)) begin
              cnt_n   = '0;
              state_n = (BLANK_CYC == 0) ? DRIVE : BLANK;
              if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                idx_n        = '0;
                frame_done_n = 1'b1;
              end else begin
                idx_n = idx + 1'b1;
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end

    // The copy happens on the same edge that starts the next frame, so the
    // output mux reads the shadow directly when the copy is taking place.
    apply     = pending & ((state == IDLE) | frame_done_n);
    pending_n = apply ? 1'b0 : (pending | wr.commit);

    seg_src   = apply ? shadow_seg[idx_n]   : active_seg[idx_n];
    blink_src = apply ? shadow_blink[idx_n] : active_blink[idx_n];

    dig_sel_n = '0;
    seg_n     = '0;
    if (state_n == DRIVE) begin
      dig_sel_n = NUM_DIGITS'(1) << idx_n;
      seg_n     = seg_src & ~{SEG_W{blink_src & flash_s}};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    if (!reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      flash_s    <= 1'b0;
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      dig_sel    <= '0;
      seg_out    <= '0;
      frame_done <= 1'b0;
      pending    <= 1'b0;
    end else begin
      s1         <= scan_clk;
      s2         <= s1;
      flash_s    <= flash_clk;
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      dig_sel    <= dig_sel_n;
      seg_out    <= seg_n;
      frame_done <= frame_done_n;
      pending    <= pending_n;
    end
  end

  // NOTE: the frame buffers are reset explicitly because a dark display after
  // reset is required; this keeps them in flops rather than RAM macros.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_seg[i]   <= '0;
        shadow_blink[i] <= 1'b0;
        active_seg[i]   <= '0;
        active_blink[i] <= 1'b0;
      end
    end else begin
      if (wr_accept) begin
        shadow_seg[wr.wr_addr[IDX_W-1:0]]   <= wr.wr_data;
        shadow_blink[wr.wr_addr[IDX_W-1:0]] <= wr.wr_blink;
      end
      if (apply) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active_seg[i]   <= shadow_seg[i];
          active_blink[i] <= shadow_blink[i];
        end
      end
    end
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Multiplexed LED/7-segment display scan controller. It uses the 1 MHz scan_clk to step one-hot digit selects through NUM_DIGITS digits, inserting a blanking gap between digits to prevent ghosting. It applies per-digit blink gated by the 10 Hz flash_clk. Segment data comes from a double-buffered frame store: host writes go to a shadow buffer through a valid/ready port and are committed to the displayed buffer only at a frame boundary, so a frame never shows a mix of old and new data.

Parameters:
NUM_DIGITS, 8, number of digits scanned; 2..2**ADDR_W.
ADDR_W, 3, width of wr_addr.
SEG_W, 8, segments per digit (7 + dp).
DWELL, 16, scan ticks each digit is driven; >=1.
BLANK_CYC, 2, scan ticks of all-off before each digit; 0 disables blanking.

Ports:
clk  in  1  system clock, 20 MHz
reset  in  1  synchronous, active-low
scan_clk  in  1  1 MHz level; rising edge = scan tick
flash_clk  in  1  10 Hz level; high = blink-off phase
enable  in  1  1 = scanning active
wr_valid  in  1  shadow write request
wr_ready  out  1  shadow write accepted when valid&ready
wr_addr  in  ADDR_W  digit index to write
wr_data  in  SEG_W  segment pattern, active-high
wr_blink  in  1  blink flag for that digit
commit  in  1  pulse: request shadow->active copy
commit_pending  out  1  commit requested, not yet applied
dig_sel  out  NUM_DIGITS  one-hot digit enable, active-high
seg_out  out  SEG_W  segment drive, active-high
frame_done  out  1  1-cycle pulse at end of last digit dwell
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0 at posedge clk): state IDLE; idx=0; tick counter=0; dig_sel=0; seg_out=0; frame_done=0; commit_pending=0; wr_ready=1; shadow and active buffers (seg+blink) all 0; synchronizer flops 0. Reset mid-frame aborts immediately, with no frame_done.
- Tick: scan_clk is registered twice (s1, s2). tick = s1 & ~s2 is consumed at the edge after s1 first samples high. There is exactly one tick per scan_clk rising edge. flash_s = flash_clk registered once.
- FSM:
  - IDLE: outputs zero. When enable=1, go to BLANK (or to DRIVE if BLANK_CYC=0) with idx=0 and counter=0.
  - BLANK: dig_sel=0, seg_out=0. Counter increments per tick. On the tick where counter reaches BLANK_CYC-1, go to DRIVE and clear the counter.
  - DRIVE: dig_sel=1<<idx; seg_out = active_seg[idx] & ~{SEG_W{active_blink[idx] & flash_s}}, re-evaluated every clk cycle. On the tick where counter reaches DWELL-1:
    - If idx=NUM_DIGITS-1: idx wraps to 0 and frame_done pulses on that edge.
    - Otherwise idx increments.
    - Next state is BLANK, or DRIVE if BLANK_CYC=0.
- enable=0 in any state: go to IDLE at the next edge; dig_sel and seg_out become 0 on that edge; no frame_done. Re-enable restarts at digit 0.
- dig_sel and seg_out are registered and change on the same edge as the state/idx update. A flash_s or commit change reaches seg_out within 1 cycle.
- Write port:
  - wr_ready = ~commit_pending.
  - Accepted write updates shadow[wr_addr] on that edge.
  - wr_addr >= NUM_DIGITS: accepted (ready honoured), data discarded.
- Commit:
  - commit=1 sets commit_pending. commit while already pending is ignored.
  - A write accepted in the same cycle as commit is included in the commit.
  - Copy shadow->active and clear commit_pending on the edge that asserts frame_done, or on the next edge if state is IDLE.
  - The new data is displayed from digit 0 of the following frame.
- Frame period = NUM_DIGITS*(BLANK_CYC+DWELL) ticks.

Test Plan:
1. Reset: hold reset=0 for 5 clk with random inputs -> dig_sel=0, seg_out=0, wr_ready=1, commit_pending=0, busy=0, frame_done=0.
2. Scan timing (NUM_DIGITS=4, DWELL=4, BLANK_CYC=2, enable=1): write digits 0..3 = 8'h3F, 8'h06, 8'h5B, 8'h4F, then commit -> each digit is driven for exactly 4 ticks after 2 all-off ticks, in order 0001, 0010, 0100, 1000; frame_done pulses once every 24 ticks; seg_out matches the digit data.
3. Blink: digit 2 has wr_blink=1; toggle flash_clk -> seg_out for digit 2 is 0 while flash_s=1 and 8'h5B while flash_s=0; other digits are unaffected.
4. Commit mid-frame: during digit 1, write digit 0 = 8'h7F and commit -> wr_ready=0 until frame_done; digit 1..3 segments unchanged; the next frame shows digit 0 = 8'h7F; a write attempted while pending is stalled and completes after the commit.
5. enable=0 mid-DRIVE on digit 2 -> outputs 0 on the next edge, busy=0, no frame_done; re-enable -> BLANK, then digit 0.
6. Edge cases: wr_addr=5 with NUM_DIGITS=4 -> accepted with no buffer change. BLANK_CYC=0 -> digits are back-to-back with no zero gap. reset=0 mid-frame -> all outputs and buffers are 0.
